switch_debouncer: RTL and testbench
===================================

Name: switch_debouncer

Overview:
- Conditions the raw 3-bit mode-select slide switches before they drive the LED-pattern select mux.
- Per bit: 2-flop synchronizer, then a stability counter. The debounced value updates only after the input has held a new level for DEB_CYCLES consecutive clocks.
- Outputs: the debounced word, a one-cycle change strobe, and an all-stable flag.
- Sits between the board switch pins and the pattern-select control stage, in the system clock domain (24 MHz).

Parameters:
- WIDTH, 3, number of switch bits debounced independently.
- DEB_CYCLES, 480000, clocks a new level must persist before acceptance (20 ms at 24 MHz); legal range 1..2^CNT_WIDTH-1.
- CNT_WIDTH, 19, per-bit counter width; must satisfy 2^CNT_WIDTH > DEB_CYCLES.

Ports:
- CLK_In  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- Sw_In  input  WIDTH  raw asynchronous switch levels.
- Ctrl_Out  output  WIDTH  debounced switch word; feeds the select mux.
- Ctrl_Chg  output  1  one-cycle pulse on the cycle Ctrl_Out changes in any bit.
- Ctrl_Stable  output  1  high when every bit is in IDLE (sync value equals debounced value).

Behaviour:
- Reset (RST high at a rising edge):
  - sync1, sync2, Ctrl_Out, Ctrl_Chg and all counters go to 0.
  - Every bit state goes to IDLE.
  - Ctrl_Stable is combinational from state, so it reads 1 after reset.
- RST is sampled only on CLK_In edges. Asserting it mid-count aborts the count, with no partial update and no Ctrl_Chg pulse.
- Synchronizer: sync1 <= Sw_In, sync2 <= sync1, every cycle. Only sync2 is used downstream.
- Per-bit FSM, states IDLE and COUNT:
  - IDLE, sync2 == Ctrl_Out[i]: cnt = 0, stay IDLE.
  - IDLE, sync2 != Ctrl_Out[i]: go to COUNT, cnt <= 1. If DEB_CYCLES == 1, Ctrl_Out[i] <= sync2 on this same edge and the bit stays IDLE.
  - COUNT, sync2 == Ctrl_Out[i] (bounce back): cnt <= 0, go to IDLE, no output change.
  - COUNT, sync2 != Ctrl_Out[i], cnt < DEB_CYCLES-1: cnt <= cnt+1.
  - COUNT, sync2 != Ctrl_Out[i], cnt == DEB_CYCLES-1: Ctrl_Out[i] <= sync2, cnt <= 0, go to IDLE.
- Latency: a clean level change on Sw_In first sampled at edge k appears on Ctrl_Out at edge k+DEB_CYCLES+1.
- Any glitch shorter than DEB_CYCLES synchronized cycles never reaches Ctrl_Out.
- Ctrl_Chg: registered. High for exactly the one cycle following any edge where Ctrl_Out changed; otherwise 0.
- Simultaneous events: bits are fully independent. Several bits accepting on the same edge produce one Ctrl_Chg pulse, not one per bit.
- Counter never wraps. It saturates by construction because acceptance resets it.
- No handshake. The consumer samples Ctrl_Out each cycle; Ctrl_Chg is informational.
- Power-up with a switch already high: after reset Ctrl_Out = 0. The bit then counts and Ctrl_Out follows after DEB_CYCLES+1 edges from the first post-reset sample. This startup transition is a normal change and pulses Ctrl_Chg.

Test Plan (DEB_CYCLES=8, CNT_WIDTH=4, WIDTH=3):
- Reset with Sw_In=3'b000, then hold 20 cycles -> Ctrl_Out=000, Ctrl_Chg never high, Ctrl_Stable=1 throughout.
- Sw_In 000->001 clean, first sampled at edge k -> Ctrl_Out=001 at edge k+9; Ctrl_Chg high only in cycle k+9..k+10; Ctrl_Stable low from edge k+2 until edge k+9.
- Bit1 bounce: high 5 cycles, low 2, high 3, low -> Ctrl_Out stays 000, Ctrl_Chg never asserts, Ctrl_Stable returns to 1.
- Sw_In 000->101 on one edge -> both bits update on the same edge to 101, exactly one Ctrl_Chg pulse.
- Sw_In 000->010, RST asserted 4 cycles into the count, then released with Sw_In still 010 -> Ctrl_Out=000 right after reset, then becomes 010 exactly 9 edges after the first post-reset sample.
- Reset with Sw_In=3'b111 held -> Ctrl_Out=000 after reset, transitions to 111 after DEB_CYCLES+1 edges, single Ctrl_Chg pulse.

Source files
------------

// File: rtl/switch_debouncer.sv
// Debounces a bank of slide switches: each bit is synchronized, then accepted
// only after it holds a new level for DEB_CYCLES consecutive clocks.
module switch_debouncer #(
  parameter int WIDTH      = 3,
  parameter int DEB_CYCLES = 480000,
  parameter int CNT_WIDTH  = 19
) (
  input  logic             CLK_In,
  input  logic             RST,
  input  logic [WIDTH-1:0] Sw_In,
  output logic [WIDTH-1:0] Ctrl_Out,
  output logic             Ctrl_Chg,
  output logic             Ctrl_Stable
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEB_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [WIDTH-1:0]     sync1_q, sync1_d;
  logic [WIDTH-1:0]     sync2_q, sync2_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic                 chg_q, chg_d;
  state_t               state_q [WIDTH];
  state_t               state_d [WIDTH];
  logic [CNT_WIDTH-1:0] cnt_q [WIDTH];
  logic [CNT_WIDTH-1:0] cnt_d [WIDTH];
  logic                 stable;

  always_comb begin
    sync1_d = Sw_In;
    sync2_d = sync1_q;
    out_d   = out_q;
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (sync2_q[i] != out_q[i]) begin
            // A one-cycle debounce window accepts on the very first mismatch.
            if (DEB_CYCLES == 1) begin
              out_d[i] = sync2_q[i];
              cnt_d[i] = '0;
            end else begin
              state_d[i] = COUNT;
              cnt_d[i]   = CNT_ONE;
            end
          end else begin
            cnt_d[i] = '0;
          end
        end
        COUNT: begin
          if (sync2_q[i] == out_q[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            out_d[i]   = sync2_q[i];
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
    chg_d = (out_d != out_q);
  end

  always_ff @(posedge CLK_In) begin
    if (RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
      out_q   <= '0;
      chg_q   <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      out_q   <= out_d;
      chg_q   <= chg_d;
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    stable = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (state_q[i] != IDLE) stable = 1'b0;
    end
  end

  assign Ctrl_Out    = out_q;
  assign Ctrl_Chg    = chg_q;
  assign Ctrl_Stable = stable;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: directed scenarios plus random switch activity,
// checked every cycle against a sliding-window reference model.
module tb_switch_debouncer;

  localparam int WIDTH = 3;
  localparam int DEB   = 8;
  localparam int CNTW  = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] sw;
  logic [WIDTH-1:0] ctrlOut;
  logic             ctrlChg;
  logic             ctrlStable;

  int checks;
  int failures;
  int chgCount;
  int lat;

  // Reference model: a bit flips once the last DEB samples seen after the
  // synchronizer all disagree with the current debounced value.
  logic [WIDTH-1:0] ms1, ms2, mOut;
  logic             mChg, mStable;
  logic [WIDTH-1:0] hist[$];

  switch_debouncer #(
    .WIDTH(WIDTH),
    .DEB_CYCLES(DEB),
    .CNT_WIDTH(CNTW)
  ) dut (
    .CLK_In(clk),
    .RST(rst),
    .Sw_In(sw),
    .Ctrl_Out(ctrlOut),
    .Ctrl_Chg(ctrlChg),
    .Ctrl_Stable(ctrlStable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelEdge(input logic [WIDTH-1:0] s, input logic r);
    logic [WIDTH-1:0] sample;
    logic [WIDTH-1:0] nOut;
    logic             allDiff;
    if (r) begin
      ms1 = '0; ms2 = '0; mOut = '0; mChg = 1'b0; mStable = 1'b1;
      hist.delete();
    end else begin
      sample = ms2;
      hist.push_back(sample);
      if (hist.size() > DEB) void'(hist.pop_front());
      nOut = mOut;
      if (hist.size() == DEB) begin
        for (int b = 0; b < WIDTH; b++) begin
          allDiff = 1'b1;
          foreach (hist[j]) if (hist[j][b] == mOut[b]) allDiff = 1'b0;
          if (allDiff) nOut[b] = ~mOut[b];
        end
      end
      mChg    = (nOut != mOut);
      mOut    = nOut;
      mStable = (sample == mOut);
      ms2     = ms1;
      ms1     = s;
    end
  endtask

  task automatic checkOutput();
    checkVal("ctrl_out", 32'(ctrlOut), 32'(mOut));
    checkVal("ctrl_chg", 32'(ctrlChg), 32'(mChg));
    checkVal("ctrl_stable", 32'(ctrlStable), 32'(mStable));
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] s, input logic r);
    @(negedge clk);
    sw  = s;
    rst = r;
    modelEdge(s, r);
    @(posedge clk);
    #1;
    if (ctrlChg === 1'b1) chgCount++;
    checkOutput();
  endtask

  // Holds s and reports how many edges after its first sample the output
  // reached target (-1 if it never did within the budget).
  task automatic measureLatency(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] target,
                                output int l);
    l = -1;
    for (int j = 0; j < 20; j++) begin
      applyStimulus(s, 1'b0);
      if (l < 0 && ctrlOut === target) l = j;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    chgCount = 0;
    sw       = '0;
    rst      = 1'b1;
    ms1 = '0; ms2 = '0; mOut = '0; mChg = 1'b0; mStable = 1'b1;

    // Quiet switches after reset
    applyStimulus(3'b000, 1'b1);
    applyStimulus(3'b000, 1'b1);
    chgCount = 0;
    repeat (20) applyStimulus(3'b000, 1'b0);
    checkVal("quiet_chg_count", 32'(chgCount), 32'd0);

    // Clean single-bit change
    measureLatency(3'b001, 3'b001, lat);
    checkVal("lat_001", 32'(lat), 32'(DEB + 1));
    checkVal("chg_count_001", 32'(chgCount), 32'd1);

    // Bounce on bit1 never reaches the output
    applyStimulus(3'b000, 1'b1);
    chgCount = 0;
    repeat (5) applyStimulus(3'b010, 1'b0);
    repeat (2) applyStimulus(3'b000, 1'b0);
    repeat (3) applyStimulus(3'b010, 1'b0);
    repeat (12) applyStimulus(3'b000, 1'b0);
    checkVal("bounce_chg_count", 32'(chgCount), 32'd0);
    checkVal("bounce_out", 32'(ctrlOut), 32'd0);
    checkVal("bounce_stable", 32'(ctrlStable), 32'd1);

    // Two bits accepting together give one pulse
    chgCount = 0;
    measureLatency(3'b101, 3'b101, lat);
    checkVal("lat_101", 32'(lat), 32'(DEB + 1));
    checkVal("chg_count_101", 32'(chgCount), 32'd1);

    // Reset in the middle of a count aborts it
    applyStimulus(3'b000, 1'b1);
    chgCount = 0;
    repeat (4) applyStimulus(3'b010, 1'b0);
    applyStimulus(3'b010, 1'b1);
    checkVal("abort_out", 32'(ctrlOut), 32'd0);
    checkVal("abort_chg_count", 32'(chgCount), 32'd0);
    measureLatency(3'b010, 3'b010, lat);
    checkVal("lat_after_abort", 32'(lat), 32'(DEB + 1));

    // Power-up with all switches already high
    applyStimulus(3'b111, 1'b1);
    applyStimulus(3'b111, 1'b1);
    chgCount = 0;
    checkVal("powerup_out", 32'(ctrlOut), 32'd0);
    measureLatency(3'b111, 3'b111, lat);
    checkVal("lat_powerup", 32'(lat), 32'(DEB + 1));
    checkVal("chg_count_powerup", 32'(chgCount), 32'd1);

    // Random switch activity with occasional resets
    for (int seg = 0; seg < 60; seg++) begin
      if ($urandom_range(0, 19) == 0) begin
        repeat (2) applyStimulus(3'($urandom_range(0, 7)), 1'b1);
      end else begin
        logic [WIDTH-1:0] v;
        int hold;
        v    = 3'($urandom_range(0, 7));
        hold = $urandom_range(1, 12);
        repeat (hold) applyStimulus(v, 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
